// File: rtl/fifo_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_unpacker
// Brief    : Pulls words from a synchronous FIFO into a 2-entry buffer and
//            serialises each word LSB-first onto a valid/ready beat stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_r_en_o,
  output logic [OUT_WIDTH-1:0]  m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_first_o,
  output logic                  busy_o
);

  localparam int RATIO   = DATA_WIDTH / OUT_WIDTH;
  localparam int c_idx_w = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(RATIO - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_CAP    = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_occ;
  logic [c_idx_w-1:0]    r_idx;

  logic                  w_issue;
  logic                  w_cap;
  logic                  w_accept;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head_word;
  logic [OUT_WIDTH-1:0]  w_beats [RATIO];

  // A read may only start with a guaranteed free slot when its data lands.
  assign w_issue  = enable_i && !fifo_empty_i && (r_occ < 2'd2);
  assign w_cap    = (r_state == S_CAP);
  assign w_accept = m_valid_o && m_ready_i;
  assign w_pop    = w_accept && (r_idx == c_last_idx);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_issue) w_state_next = S_REQ;
      S_REQ:    w_state_next = S_CAP;
      S_CAP:    w_state_next = S_SETTLE;
      S_SETTLE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_occ    <= 2'd0;
      r_idx    <= '0;
    end else begin
      if (w_cap) begin
        r_buf[r_tail] <= fifo_data_i;
        r_tail        <= ~r_tail;
      end
      if (w_accept) begin
        if (r_idx == c_last_idx) begin
          r_idx  <= '0;
          r_head <= ~r_head;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      // Capture and last-beat pop in one cycle cancel out on the count.
      case ({w_cap, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign w_head_word = r_buf[r_head];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_beats
    assign w_beats[gi] = w_head_word[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  assign fifo_r_en_o = (r_state == S_REQ);
  assign m_valid_o   = (r_occ != 2'd0);
  assign m_data_o    = w_beats[r_idx];
  assign m_first_o   = m_valid_o && (r_idx == '0);
  assign busy_o      = (r_state != S_IDLE) || m_valid_o;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_unpacker
// Brief    : Word-level model of FIFO contents and beat stream; directed plus
//            randomized traffic with per-cycle comparison of DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_unpacker;

  localparam int DW    = 32;
  localparam int OW    = 8;
  localparam int RATIO = DW / OW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          fifo_empty_i = 1'b1;
  logic [DW-1:0] fifo_data_i  = '0;
  logic          fifo_r_en_o;
  logic [OW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          m_first_o;
  logic          busy_o;

  fifo_stream_unpacker #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i (fifo_data_i),
    .fifo_r_en_o (fifo_r_en_o),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_first_o   (m_first_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // FIFO: one-cycle read latency, empty flag registered from the post-read count.
  logic [DW-1:0] fifo_q [$];
  always @(posedge clk_i) begin
    if (fifo_r_en_o && fifo_q.size() != 0) fifo_data_i <= fifo_q.pop_front();
    fifo_empty_i <= (fifo_q.size() == 0);
  end

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  // Model: words popped from the FIFO become visible two cycles after the read.
  typedef struct { logic [DW-1:0] w; int avail; } ent_t;
  ent_t          mdl [$];
  int            mdl_idx  = 0;
  int            last_ren = -100;
  int            n_ren    = 0;
  int            n_beats  = 0;
  int            ren_cyc [$];
  int            beat_cyc [$];
  logic [OW-1:0] beat_log [$];
  logic          prev_en   = 1'b0;
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          exp_valid;
  logic [DW-1:0] cur_word;

  always @(negedge clk_i) begin
    if (rst_i) begin
      mdl.delete();
      mdl_idx   = 0;
      last_ren  = -100;
      prev_hold = 1'b0;
      prev_en   = enable_i;
    end else begin
      if (fifo_r_en_o) begin
        n_ren++;
        ren_cyc.push_back(cyc);
        check("ren_spacing", 64'(cyc - last_ren >= 4), 1);
        check("ren_slot_free", 64'(mdl.size() <= 1), 1);
        check("ren_enabled", prev_en, 1);
        check("ren_fifo_nonempty", 64'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) mdl.push_back('{w: fifo_q[0], avail: cyc + 2});
        last_ren = cyc;
      end
      exp_valid = (mdl.size() > 0) && (mdl[0].avail <= cyc);
      check("m_valid", m_valid_o, exp_valid);
      check("busy", busy_o, 64'((mdl.size() > 0) || (cyc - last_ren <= 2)));
      if (prev_hold) check("hold_data", m_data_o, prev_data);
      if (exp_valid) begin
        cur_word = mdl[0].w;
        check("m_data", m_data_o, cur_word[mdl_idx*OW +: OW]);
        check("m_first", m_first_o, 64'(mdl_idx == 0));
        if (m_ready_i) begin
          n_beats++;
          beat_log.push_back(m_data_o);
          beat_cyc.push_back(cyc);
          mdl_idx++;
          if (mdl_idx == RATIO) begin
            mdl_idx = 0;
            void'(mdl.pop_front());
          end
        end
      end
      prev_hold = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
      prev_en   = enable_i;
    end
  end

  logic [OW-1:0] t2_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int            base_ren, base_beats, vcyc, seen, k, n_words;
  logic [DW-1:0] next_word;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while ((fifo_q.size() != 0 || busy_o) && n < max_cyc) begin
      step();
      n++;
    end
    check({tag, "_drain_in_time"}, 64'(n < max_cyc), 1);
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; m_ready_i = 1'b0;
    #2;
    check("rst_valid", m_valid_o, 0);
    check("rst_ren", fifo_r_en_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_first", m_first_o, 0);
    repeat (3) step();
    rst_i = 1'b0;

    // Reset then idle with an empty FIFO
    enable_i = 1'b1; m_ready_i = 1'b1; base_ren = n_ren;
    repeat (20) step();
    check("t1_no_reads", n_ren - base_ren, 0);
    check("t1_valid", m_valid_o, 0);
    check("t1_busy", busy_o, 0);

    // Single word
    base_ren = n_ren; base_beats = n_beats; vcyc = -1;
    fifo_q.push_back(32'h44332211);
    for (k = 0; k < 40; k++) begin
      step();
      if (m_valid_o && vcyc < 0) vcyc = cyc;
    end
    check("t2_reads", n_ren - base_ren, 1);
    check("t2_latency", vcyc - ren_cyc[ren_cyc.size()-1], 2);
    check("t2_beats", n_beats - base_beats, 4);
    for (int i = 0; i < 4; i++) check("t2_beat_val", beat_log[base_beats + i], t2_exp[i]);
    check("t2_beats_consecutive", beat_cyc[base_beats + 3] - beat_cyc[base_beats], 3);

    // Backpressure: buffer fills to two words, then parks
    m_ready_i = 1'b0; base_ren = n_ren; base_beats = n_beats;
    fifo_q.push_back(32'hA3A2A1A0);
    fifo_q.push_back(32'hB3B2B1B0);
    fifo_q.push_back(32'hC3C2C1C0);
    repeat (40) step();
    check("t3_reads_parked", n_ren - base_ren, 2);
    check("t3_read_gap", ren_cyc[base_ren + 1] - ren_cyc[base_ren], 4);
    check("t3_held_data", m_data_o, 8'hA0);
    check("t3_held_first", m_first_o, 1);
    m_ready_i = 1'b1;
    drain("t3", 100);
    check("t3_reads_total", n_ren - base_ren, 3);
    check("t3_beats", n_beats - base_beats, 12);
    check("t3_last_beat", beat_log[beat_log.size()-1], 8'hC3);

    // Streaming random words
    base_ren = n_ren; base_beats = n_beats;
    for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
    drain("t4", 200);
    check("t4_reads", n_ren - base_ren, 8);
    for (int i = 1; i < 8; i++) check("t4_read_spacing", ren_cyc[base_ren + i] - ren_cyc[base_ren + i - 1], 4);
    check("t4_no_gaps", beat_cyc[base_beats + 31] - beat_cyc[base_beats], 31);

    // Enable dropped on the second read's REQ cycle
    base_ren = n_ren; base_beats = n_beats; seen = 0;
    for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
    for (k = 0; k < 60 && seen < 2; k++) begin
      step();
      if (fifo_r_en_o) seen++;
    end
    enable_i = 1'b0;
    repeat (30) step();
    check("t5_reads_gated", n_ren - base_ren, 2);
    check("t5_beats_gated", n_beats - base_beats, 8);
    check("t5_idle_gated", busy_o, 0);
    enable_i = 1'b1;
    drain("t5", 100);
    check("t5_reads_total", n_ren - base_ren, 4);

    // Asynchronous reset while beat 2 of the second word is presented
    base_beats = n_beats;
    for (int i = 0; i < 6; i++) fifo_q.push_back($urandom);
    for (k = 0; k < 80; k++) begin
      step();
      if (m_valid_o && mdl_idx == 2 && n_beats - base_beats >= 4) break;
    end
    check("t6_reached_beat2", 64'(k < 80), 1);
    #2 rst_i = 1'b1;
    #1;
    check("t6_rst_valid", m_valid_o, 0);
    check("t6_rst_ren", fifo_r_en_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_data", m_data_o, 0);
    step();
    rst_i = 1'b0;
    next_word = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    for (k = 0; k < 20 && !m_valid_o; k++) step();
    check("t6_restart_data", m_data_o, next_word[OW-1:0]);
    check("t6_restart_first", m_first_o, 1);
    drain("t6", 200);

    // Randomized enable, backpressure and FIFO refill
    base_ren = n_ren; base_beats = n_beats; n_words = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      m_ready_i = ($urandom_range(0, 3) != 0);
      enable_i  = ($urandom_range(0, 7) != 0);
      if (n_words < 30 && $urandom_range(0, 5) == 0) begin
        fifo_q.push_back($urandom);
        n_words++;
      end
    end
    m_ready_i = 1'b1; enable_i = 1'b1;
    drain("t7", 300);
    check("t7_all_words_read", n_ren - base_ren, n_words);
    check("t7_beats", n_beats - base_beats, RATIO * (n_ren - base_ren));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_stream_unpacker.md
Name: fifo_stream_unpacker

Overview:
- Downstream consumer of the synchronous FIFO.
- Pulls DATA_WIDTH words out through the FIFO's read-enable/data/empty interface and buffers them in a 2-entry word buffer.
- Serialises each word into DATA_WIDTH/OUT_WIDTH narrow beats, LSB-first, on a valid/ready output stream.
- Paces reads so the FIFO's one-cycle read latency and lagging empty flag are never violated.

Parameters:
DATA_WIDTH, 32, width of FIFO words; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 8, width of each output beat.
RATIO, DATA_WIDTH/OUT_WIDTH (localparam), beats per word; must be >= 1.

Ports:
clk_i  in  1  sole clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
enable_i  in  1  when high, the block may issue new FIFO reads.
fifo_empty_i  in  1  FIFO empty flag.
fifo_data_i  in  DATA_WIDTH  FIFO read data; valid in the cycle after the read request.
fifo_r_en_o  out  1  FIFO read request; registered, single-cycle pulse.
m_data_o  out  OUT_WIDTH  output beat.
m_valid_o  out  1  beat valid.
m_ready_i  in  1  downstream accepts the beat.
m_first_o  out  1  current beat is beat 0 of its word.
busy_o  out  1  read FSM not in IDLE, or buffer non-empty.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset (async assert, sync release): read FSM=IDLE, fifo_r_en_o=0, buffer occupancy=0, head/tail=0, beat index=0, buffer contents=0, m_valid_o=0, m_data_o=0, m_first_o=0, busy_o=0.
- Read FSM states: IDLE, REQ, CAP, SETTLE.
  - IDLE->REQ when enable_i && !fifo_empty_i && occupancy<2. Otherwise stay in IDLE.
  - REQ: fifo_r_en_o=1, decoded from the state register only. Always ->CAP.
  - CAP: fifo_data_i written into buffer[tail]; tail toggles; occupancy+1. Always ->SETTLE.
  - SETTLE: no action; lets fifo_empty_i reflect the updated pointer. Always ->IDLE.
- fifo_r_en_o is high for exactly 1 cycle per word. Minimum spacing between reads is 4 cycles, i.e. at most one read in flight.
- Latency:
  - fifo_r_en_o rises 1 cycle after IDLE sees the issue condition.
  - The word lands in the buffer at the end of the cycle after the REQ cycle.
  - With an empty buffer, m_valid_o rises 2 cycles after the REQ cycle.
- Buffer: 2 entries with head/tail pointers and a 2-bit occupancy count.
  - A slot is always free at CAP, because occupancy only increments in CAP and IDLE checks occupancy<2.
- Output stream:
  - m_valid_o = (occupancy!=0).
  - m_data_o = buffer[head][idx*OUT_WIDTH +: OUT_WIDTH].
  - m_first_o = m_valid_o && idx==0.
  - m_data_o is held stable while m_valid_o && !m_ready_i.
- Beat accept (m_valid_o && m_ready_i): idx+1.
  - When idx==RATIO-1: idx wraps to 0, head toggles, occupancy-1.
  - With RATIO==1, every accepted beat pops a word.
- Simultaneous CAP and last-beat pop in the same cycle: occupancy unchanged; head and tail both toggle.
- enable_i low: no new REQ. Any REQ/CAP/SETTLE in progress completes, and buffered words keep draining.
- m_ready_i low indefinitely: the buffer fills to 2, the FSM parks in IDLE, and no reads are issued.
- Reset mid-operation: all state clears immediately. A pending FIFO read whose data was not captured is lost, because the FIFO is reset in the same domain.
- Pointer and index arithmetic is modulo its width; idx counter width is clog2(RATIO), with a minimum of 1 bit.

Test Plan:
1. Reset then idle: rst_i pulsed, fifo_empty_i=1, enable_i=1 for 20 cycles -> fifo_r_en_o stays 0, m_valid_o=0, busy_o=0.
2. Single word: FIFO holds 0x44332211, m_ready_i=1 -> one fifo_r_en_o pulse. m_valid_o rises 2 cycles after the REQ cycle. Beats are 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, m_first_o only on 0x11. Then m_valid_o=0 and no further reads.
3. Backpressure: FIFO holds 3 words, m_ready_i=0 -> exactly 2 fifo_r_en_o pulses, 4 cycles apart, then none. m_data_o held at word0 beat 0. Raising m_ready_i -> all 12 beats appear in order, and the third read issues once occupancy drops to 1.
4. Streaming: 8 words, m_ready_i=1 -> 32 beats in order with no gaps after the first beat. Read spacing is exactly 4 cycles, and every consecutive fifo_r_en_o pair is separated by 3 low cycles.
5. Enable gating: enable_i dropped on the REQ cycle of word 1 of 4 -> word 1 is still captured and streamed, and no REQ for word 2 until enable_i returns.
6. Async reset mid-stream: rst_i asserted mid-cycle while beat 2 of a word is presented -> m_valid_o, fifo_r_en_o and occupancy go to 0 without waiting for a clock edge. After release, streaming restarts cleanly at beat 0 of the next FIFO word.
